// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : Six-digit multiplexed BCD display scanner with PWM brightness,
//            leading-zero blanking and a frame-synchronous update handshake.
// Revision : 1.0  initial release
// ============================================================================
module disp_scan_ctrl #(
    parameter int DIV  = 50000,
    parameter int NDIG = 6
) (
    input  logic        clk,
    input  logic        cr,
    input  logic        en,
    input  logic        wr_req,
    input  logic [23:0] wr_data,
    output logic        wr_ack,
    input  logic [1:0]  bright,
    input  logic        lzb,
    output logic [2:0]  bcdsel,
    output logic [3:0]  bcd_data,
    output logic        digit_on,
    output logic        frame_start
);

    localparam int             c_PW       = $clog2(DIV);
    localparam logic [c_PW-1:0] c_DIV_LAST = c_PW'(DIV - 1);
    localparam logic [2:0]     c_LAST_DIG = 3'(NDIG - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SCAN = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_nxt;
    logic [1:0]      r_sub;
    logic [1:0]      w_sub_nxt;
    logic [2:0]      r_sel;
    logic [2:0]      w_sel_nxt;
    logic [23:0]     r_active;
    logic [23:0]     w_active_nxt;
    logic [23:0]     r_pending;
    logic            r_pend_valid;
    logic [3:0]      r_bcd;
    logic            r_fs;
    logic [7:0]      w_blank;

    logic w_scan;
    logic w_tick;
    logic w_slot_end;
    logic w_wrap;
    logic w_commit;
    logic w_accept;

    assign w_scan     = (r_state == c_SCAN);
    assign w_tick     = w_scan && (r_presc == c_DIV_LAST);
    assign w_slot_end = w_tick && (r_sub == 2'd3);
    assign w_wrap     = w_slot_end && (r_sel == c_LAST_DIG) && en;
    // Accept and commit are exclusive because commit needs pend_valid set.
    assign w_commit   = r_pend_valid && (!w_scan || w_wrap);
    assign w_accept   = wr_req && !r_pend_valid;

    // Digit k is blanked when it and every digit above it are zero.
    assign w_blank[0]   = 1'b0;
    assign w_blank[7:6] = 2'b00;
    for (genvar k = 1; k < 6; k++) begin : g_blank
        assign w_blank[k] = lzb && (r_active[23:4*k] == '0);
    end

    always_ff @(posedge clk) begin
        if (cr) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  w_state_nxt = en ? c_SCAN : c_IDLE;
            c_SCAN:  w_state_nxt = en ? c_SCAN : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        wr_ack      = !cr && w_accept;
        digit_on    = !cr && w_scan && (r_sub <= bright) && !w_blank[r_sel];
        frame_start = !cr && r_fs;
        bcd_data    = cr ? 4'd0 : r_bcd;
        bcdsel      = cr ? 3'd0 : r_sel;
    end

    always_comb begin
        w_presc_nxt = '0;
        w_sub_nxt   = 2'd0;
        w_sel_nxt   = 3'd0;
        if (w_scan && en) begin
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
            w_sub_nxt   = w_tick ? r_sub + 2'd1 : r_sub;
            w_sel_nxt   = r_sel;
            if (w_slot_end) begin
                w_sel_nxt = (r_sel == c_LAST_DIG) ? 3'd0 : r_sel + 3'd1;
            end
        end
        w_active_nxt = w_commit ? r_pending : r_active;
    end

    // bcd_data is loaded from next-cycle select/active so it moves with bcdsel.
    always_ff @(posedge clk) begin
        if (cr) begin
            r_presc      <= '0;
            r_sub        <= 2'd0;
            r_sel        <= 3'd0;
            r_active     <= 24'd0;
            r_pending    <= 24'd0;
            r_pend_valid <= 1'b0;
            r_bcd        <= 4'd0;
            r_fs         <= 1'b0;
        end else begin
            r_presc  <= w_presc_nxt;
            r_sub    <= w_sub_nxt;
            r_sel    <= w_sel_nxt;
            r_active <= w_active_nxt;
            r_bcd    <= w_active_nxt[{w_sel_nxt, 2'b00} +: 4];
            r_fs     <= (!w_scan && en) || w_wrap;
            if (w_accept) begin
                r_pending    <= wr_data;
                r_pend_valid <= 1'b1;
            end else if (w_commit) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Purpose  : Self-checking bench for disp_scan_ctrl (tables, sequences, random).
// Revision : 1.0  initial release
// ============================================================================
module tb_disp_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 24 * DIV;

    logic        clk = 1'b0;
    logic        cr, en, wr_req, lzb;
    logic [23:0] wr_data;
    logic [1:0]  bright;
    logic        wr_ack, digit_on, frame_start;
    logic [2:0]  bcdsel;
    logic [3:0]  bcd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.DIV(DIV), .NDIG(6)) dut (
        .clk(clk), .cr(cr), .en(en), .wr_req(wr_req), .wr_data(wr_data),
        .wr_ack(wr_ack), .bright(bright), .lzb(lzb), .bcdsel(bcdsel),
        .bcd_data(bcd_data), .digit_on(digit_on), .frame_start(frame_start)
    );

    typedef struct {
        logic [23:0] data;
        logic        lz;
        logic [5:0]  lit;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v;
        for (int k = 0; k < 6; k++) begin
            v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    // Blanking rule: digit k>0 dark when digits 5..k of the word are all zero.
    function automatic logic is_blank(input logic [23:0] act, input logic lz, input int k);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = k; j < 6; j++) if (act[4*j +: 4] != 4'd0) all_zero = 1'b0;
        return lz && (k > 0) && all_zero;
    endfunction

    task automatic frame_check(input logic [1:0] bv, input string tag);
        int p, errs, steps, fsn;
        logic [2:0] prev;
        logic got;
        @(negedge clk); en = 1'b0; wr_req = 1'b0; bright = bv; lzb = 1'b0;
        @(negedge clk); en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk); #1;
            if (frame_start) got = 1'b1;
        end
        check({tag, "_first_fs"}, 32'(got), 32'd1);
        prev = bcdsel; p = 0; errs = 0; steps = 0; fsn = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) begin @(negedge clk); #1; p++; end
            if (frame_start) fsn++;
            if (bcdsel != prev) begin
                steps++;
                if (p != 16 || 32'(bcdsel) != 32'(prev) + 1) errs++;
                prev = bcdsel; p = 0;
            end
            if (digit_on !== (p < 4 * (int'(bv) + 1))) errs++;
        end
        check({tag, "_slot_steps"}, 32'(steps), 32'd5);
        check({tag, "_pattern_errs"}, 32'(errs), 32'd0);
        check({tag, "_fs_count"}, 32'(fsn), 32'd1);
        @(negedge clk); #1;
        check({tag, "_wrap_fs_sel"}, {31'd0, frame_start} | (32'(bcdsel) << 4), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [5:0]  mask;
        logic [23:0] dat;
        logic        got;
        @(negedge clk); en = 1'b0; wr_req = 1'b0; bright = 2'd3; lzb = v.lz;
        @(negedge clk);
        @(negedge clk); wr_req = 1'b1; wr_data = v.data; #1;
        got = wr_ack;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk); #1;
            got = wr_ack;
        end
        @(negedge clk); wr_req = 1'b0; en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk); #1;
            if (frame_start) got = 1'b1;
        end
        mask = 6'd0; dat = 24'd0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (bcdsel < 3'd6) begin
                mask[bcdsel] = mask[bcdsel] | digit_on;
                dat[{bcdsel, 2'b00} +: 4] = bcd_data;
            end
        end
        check($sformatf("tbl%0d_lit", idx), 32'(mask), 32'(v.lit));
        check($sformatf("tbl%0d_data", idx), 32'(dat), 32'(v.data));
    endtask

    initial begin : main
        logic        m_scan, m_pv, m_ack, m_commit, got;
        int          m_t, pos, dig, sub;
        logic [23:0] m_act, m_pend, acc;
        logic [2:0]  e_sel;
        logic [3:0]  e_bcd;
        logic        e_on, e_fs, e_ack;

        tbl[0] = '{24'h000305, 1'b1, 6'b000111};
        tbl[1] = '{24'h000000, 1'b1, 6'b000001};
        tbl[2] = '{24'h000000, 1'b0, 6'b111111};
        tbl[3] = '{24'hA00000, 1'b1, 6'b111111};
        tbl[4] = '{24'h0F0000, 1'b1, 6'b011111};
        tbl[5] = '{24'h654321, 1'b1, 6'b111111};
        tbl[6] = '{24'h001000, 1'b1, 6'b001111};

        cr = 1'b1; en = 1'b1; wr_req = 1'b1; wr_data = 24'h000000; bright = 2'd3; lzb = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("reset_outputs", {wr_ack, digit_on, frame_start, bcd_data, bcdsel}, 32'd0);
        cr = 1'b0; #1;
        check("ack_after_reset", 32'(wr_ack), 32'd1);
        @(negedge clk); wr_req = 1'b0;

        frame_check(2'd3, "b3");
        frame_check(2'd1, "b1");

        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // Second request while pending waits for the frame-wrap commit.
        @(negedge clk); en = 1'b0; lzb = 1'b0; bright = 2'd3;
        @(negedge clk); @(negedge clk); en = 1'b1;
        repeat (30) @(negedge clk);
        wr_req = 1'b1; wr_data = 24'h654321; #1;
        check("mid_frame_ack", 32'(wr_ack), 32'd1);
        @(negedge clk); wr_data = 24'h111111; #1;
        got = wr_ack;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            @(negedge clk); #1;
            got = wr_ack;
        end
        check("second_ack_at_frame", {got, frame_start, bcdsel, bcd_data}, {24'd0, 1'b1, 1'b1, 3'd0, 4'd1});
        @(negedge clk); wr_req = 1'b0;

        got = 1'b0;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            @(negedge clk); #1;
            if (bcdsel == 3'd3) got = 1'b1;
        end
        en = 1'b0;
        @(negedge clk); #1;
        check("en_drop", {got, digit_on, bcdsel}, {28'd0, 1'b1, 1'b0, 3'd0});

        // Reset in mid-frame with a pending write must discard the data.
        en = 1'b1;
        repeat (40) @(negedge clk);
        wr_req = 1'b1; wr_data = 24'h999999;
        @(negedge clk); wr_req = 1'b0;
        repeat (5) @(negedge clk);
        cr = 1'b1; #1;
        check("cr_during", {wr_ack, digit_on, frame_start, bcd_data, bcdsel}, 32'd0);
        @(negedge clk); cr = 1'b0; #1;
        check("cr_after", {wr_ack, digit_on, frame_start, bcd_data, bcdsel}, 32'd0);
        acc = 24'd0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk); #1;
            acc[3:0] = acc[3:0] | bcd_data;
        end
        check("pending_discarded", 32'(acc), 32'd0);

        // Randomised run against a slot/frame arithmetic model.
        m_scan = 1'b0; m_t = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            cr = (it < 2) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) en = ~en;
            wr_req  = ($urandom_range(0, 2) == 0);
            wr_data = rand_bcd();
            if ($urandom_range(0, 29) == 0) bright = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) lzb = 1'($urandom_range(0, 1));
            #1;
            pos = m_t / DIV;
            sub = pos % 4;
            dig = (pos / 4) % 6;
            if (cr) begin
                e_ack = 1'b0; e_on = 1'b0; e_fs = 1'b0; e_bcd = 4'd0; e_sel = 3'd0;
            end else begin
                e_sel = m_scan ? 3'(dig) : 3'd0;
                e_bcd = m_act[4*int'(e_sel) +: 4];
                e_on  = m_scan && (sub <= int'(bright)) && !is_blank(m_act, lzb, dig);
                e_fs  = m_scan && (m_t % FRAME == 0);
                e_ack = wr_req && !m_pv;
            end
            check($sformatf("rand%0d ack/sel/bcd/on/fs", it),
                  {wr_ack, bcdsel, bcd_data, digit_on, frame_start},
                  {e_ack, e_sel, e_bcd, e_on, e_fs});
            @(posedge clk);
            if (cr) begin
                m_scan = 1'b0; m_t = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
            end else begin
                m_ack    = wr_req && !m_pv;
                m_commit = m_pv && (!m_scan || (en && ((m_t + 1) % FRAME == 0)));
                if (m_commit) begin m_act = m_pend; m_pv = 1'b0; end
                if (m_ack) begin m_pend = wr_data; m_pv = 1'b1; end
                if (!m_scan) begin
                    if (en) begin m_scan = 1'b1; m_t = 0; end
                end else if (en) begin
                    m_t++;
                end else begin
                    m_scan = 1'b0; m_t = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
